// File: rtl/sipo_deserializer_if.sv
// sipo_deserializer_if: serial input, word output handshake and status bundle
interface sipo_deserializer_if #(parameter int WIDTH = 8);
  localparam int CNT_W = $clog2(WIDTH);
  logic din;
  logic din_valid;
  logic clear;
  logic [WIDTH-1:0] dout;
  logic dout_valid;
  logic dout_ready;
  logic [CNT_W-1:0] bit_cnt;
  logic overrun;
  modport master (
    output din, din_valid, clear, dout_ready,
    input  dout, dout_valid, bit_cnt, overrun
  );
  modport slave (
    input  din, din_valid, clear, dout_ready,
    output dout, dout_valid, bit_cnt, overrun
  );
endinterface

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: assembles serial bits into WIDTH-bit words held in a valid/ready slot
module sipo_deserializer #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input logic clk,
  input logic reset,
  sipo_deserializer_if.slave bus
);
  typedef enum logic {EMPTY, FULL} slot_t;
  slot_t slot;
  logic [WIDTH-1:0] sreg, sreg_nx;
  logic shift, done;
  assign shift = bus.din_valid && !bus.clear;
  assign done = shift && bus.bit_cnt == CNT_W'(WIDTH - 1);
  assign sreg_nx = MSB_FIRST ? {sreg[WIDTH-2:0], bus.din} : {bus.din, sreg[WIDTH-1:1]};
  assign bus.dout_valid = slot == FULL;
  // a completed word is taken when the slot is empty or being drained this edge, else dropped
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      slot <= EMPTY;
      sreg <= '0;
      bus.bit_cnt <= '0;
      bus.dout <= '0;
      bus.overrun <= 1'b0;
    end else begin
      bus.overrun <= done && slot == FULL && !bus.dout_ready;
      if (bus.clear) begin
        sreg <= '0;
        bus.bit_cnt <= '0;
      end else if (shift) begin
        sreg <= sreg_nx;
        bus.bit_cnt <= done ? '0 : bus.bit_cnt + 1'b1;
      end
      if (done && (slot == EMPTY || bus.dout_ready)) begin
        bus.dout <= sreg_nx;
        slot <= FULL;
      end else if (bus.dout_ready) slot <= EMPTY;
    end
endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: directed checks of MSB-first and LSB-first deserializers fed in parallel
module tb_sipo_deserializer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int passed = 0;
  logic [7:0] p, q, g;
  sipo_deserializer_if #(.WIDTH(8)) a ();
  sipo_deserializer_if #(.WIDTH(8)) b ();
  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (.clk(clk), .reset(reset), .bus(a.slave));
  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .reset(reset), .bus(b.slave));
  assign b.din = a.din;
  assign b.din_valid = a.din_valid;
  assign b.clear = a.clear;
  assign b.dout_ready = a.dout_ready;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic d);
    a.din = d;
    a.din_valid = 1'b1;
    tick();
    a.din_valid = 1'b0;
  endtask
  task automatic word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send(w[i]);
  endtask
  initial begin
    a.din = 1'b0;
    a.din_valid = 1'b0;
    a.clear = 1'b0;
    a.dout_ready = 1'b0;
    p = 8'hB2;
    q = 8'h0F;
    g = 8'h96;
    #12;
    chk("rst dout", 32'(a.dout), 0);
    chk("rst valid", 32'(a.dout_valid), 0);
    chk("rst cnt", 32'(a.bit_cnt), 0);
    chk("rst overrun", 32'(a.overrun), 0);
    tick();
    reset = 1'b1;
    a.dout_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(p[7-i]);
      chk($sformatf("cnt bit%0d", i), 32'(a.bit_cnt), (i + 1) % 8);
      if (i < 7) chk($sformatf("early valid bit%0d", i), 32'(a.dout_valid), 0);
    end
    a.dout_ready = 1'b0;
    chk("msb word", 32'(a.dout), 'hB2);
    chk("msb valid", 32'(a.dout_valid), 1);
    chk("lsb word", 32'(b.dout), 'h4D);
    for (int i = 0; i < 8; i++) begin
      send(q[7-i]);
      chk($sformatf("overrun bit%0d", i), 32'(a.overrun), i == 7 ? 1 : 0);
    end
    chk("drop dout", 32'(a.dout), 'hB2);
    chk("drop valid", 32'(a.dout_valid), 1);
    chk("drop lsb dout", 32'(b.dout), 'h4D);
    chk("drop cnt", 32'(a.bit_cnt), 0);
    tick();
    chk("overrun pulse end", 32'(a.overrun), 0);
    a.dout_ready = 1'b1;
    tick();
    a.dout_ready = 1'b0;
    chk("drain valid", 32'(a.dout_valid), 0);
    chk("drain stale dout", 32'(a.dout), 'hB2);
    word(p);
    chk("b2b first", 32'(a.dout), 'hB2);
    for (int i = 0; i < 7; i++) begin
      send(q[7-i]);
      chk($sformatf("b2b hold valid%0d", i), 32'(a.dout_valid), 1);
    end
    a.dout_ready = 1'b1;
    send(q[0]);
    a.dout_ready = 1'b0;
    chk("b2b dout", 32'(a.dout), 'h0F);
    chk("b2b valid", 32'(a.dout_valid), 1);
    chk("b2b overrun", 32'(a.overrun), 0);
    chk("b2b lsb dout", 32'(b.dout), 'hF0);
    a.dout_ready = 1'b1;
    tick();
    a.dout_ready = 1'b0;
    chk("b2b drain", 32'(a.dout_valid), 0);
    for (int i = 0; i < 8; i++) begin
      send(g[7-i]);
      tick();
      if (i == 3) chk("gap cnt", 32'(a.bit_cnt), 4);
    end
    chk("gap dout", 32'(a.dout), 'h96);
    chk("gap valid", 32'(a.dout_valid), 1);
    chk("gap lsb dout", 32'(b.dout), 'h69);
    for (int i = 0; i < 5; i++) send(1'b1);
    chk("pre-clear cnt", 32'(a.bit_cnt), 5);
    a.clear = 1'b1;
    send(1'b1);
    a.clear = 1'b0;
    chk("clear cnt", 32'(a.bit_cnt), 0);
    chk("clear dout kept", 32'(a.dout), 'h96);
    chk("clear valid kept", 32'(a.dout_valid), 1);
    chk("clear overrun", 32'(a.overrun), 0);
    a.dout_ready = 1'b1;
    tick();
    a.dout_ready = 1'b0;
    word(8'hA1);
    chk("post-clear dout", 32'(a.dout), 'hA1);
    chk("post-clear lsb dout", 32'(b.dout), 'h85);
    chk("post-clear valid", 32'(a.dout_valid), 1);
    for (int i = 0; i < 3; i++) send(1'b1);
    chk("mid cnt", 32'(a.bit_cnt), 3);
    #1 reset = 1'b0;
    #1;
    chk("async rst dout", 32'(a.dout), 0);
    chk("async rst valid", 32'(a.dout_valid), 0);
    chk("async rst cnt", 32'(a.bit_cnt), 0);
    chk("async rst lsb dout", 32'(b.dout), 0);
    #1 reset = 1'b1;
    word(8'hF0);
    chk("after rst dout", 32'(a.dout), 'hF0);
    chk("after rst lsb dout", 32'(b.dout), 'h0F);
    chk("after rst valid", 32'(a.dout_valid), 1);
    chk("after rst overrun", 32'(a.overrun), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
Serial-in, parallel-out deserializer that consumes the single-bit registered output of the D flip-flop stage (q) and assembles WIDTH-bit words. Each completed word is presented on a registered output holding slot with a valid/ready handshake for downstream logic. The block provides frame resynchronisation through a synchronous clear, and flags words that are dropped because the output slot was still occupied.

Parameters:
WIDTH, 8, bits per assembled word (legal range 2..32).
MSB_FIRST, 1, 1: the first received bit lands in the MSB; 0: the first received bit lands in the LSB.
CNT_W, $clog2(WIDTH), width of the bit counter (derived; not overridden).

Ports:
clk  input  1  single clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
din  input  1  serial data bit, driven by the upstream D flip-flop q.
din_valid  input  1  din is sampled on this clock edge.
clear  input  1  synchronous discard of the partial word (resync).
dout  output  WIDTH  assembled word (holding register).
dout_valid  output  1  holding register contains an unconsumed word.
dout_ready  input  1  downstream accepts dout on this edge.
bit_cnt  output  CNT_W  number of bits collected in the current partial word.
overrun  output  1  one-cycle pulse: a completed word was dropped.

Behaviour:
- Reset (reset=0, asynchronous): shift register=0, bit_cnt=0, dout=0, dout_valid=0, overrun=0.
- The output slot has two states, EMPTY (dout_valid=0) and FULL (dout_valid=1).
- Shift, MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0], din}.
- Shift, MSB_FIRST=0: sreg <= {din, sreg[WIDTH-1:1]}.
- Shift occurs only on edges with din_valid=1 and clear=0. On such an edge, bit_cnt increments.
- Completion: an edge with din_valid=1, clear=0 and bit_cnt==WIDTH-1.
  - The completed word is the shifted value including the current din.
  - bit_cnt wraps to 0.
  - The shift register is not zeroed; it is overwritten by subsequent bits.
- Latency: dout and dout_valid update on the same edge as the completion. The word is visible one cycle after the last bit is presented.
- Slot transitions, per edge:
  - EMPTY + completion -> FULL; dout loaded.
  - FULL + dout_ready=1, no completion -> EMPTY; dout holds its stale value.
  - FULL + dout_ready=1 + completion -> stays FULL; dout loaded with the new word (back-to-back, no bubble).
  - FULL + dout_ready=0 + completion -> stays FULL; dout unchanged; the new word is dropped; overrun=1 for exactly one cycle.
  - All other cases: no change.
- dout_ready while EMPTY is ignored.
- overrun is 0 on every edge except a drop edge.
- clear=1: bit_cnt <= 0 and the shift register <= 0. The slot state, dout and dout_valid are unaffected.
- clear and din_valid on the same edge: clear wins; the bit is discarded and no completion occurs.
- Reset mid-word or mid-handshake discards everything immediately. The first din_valid after reset release is bit 0 of a new word.
- dout is stable while dout_valid=1 and dout_ready=0.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset mid-stream: after 3 bits, with a word pending, pulse reset=0 -> dout=0, dout_valid=0 and bit_cnt=0 asynchronously, without waiting for a clock edge. Then stream 8 bits 1,1,1,1,0,0,0,0 -> dout=8'hF0.
- MSB_FIRST=1, WIDTH=8, dout_ready=1, din_valid=1 for 8 cycles with bits 1,0,1,1,0,0,1,0 -> dout=8'hB2 and dout_valid=1 on the edge of the 8th bit; bit_cnt sequence 1..7 then 0.
- MSB_FIRST=0, same bit stream -> dout=8'h4D.
- Backpressure and overrun, MSB_FIRST=1:
  - Word 8'hB2 is pending with dout_ready=0; stream word 8'h0F -> overrun pulses for 1 cycle and dout stays 8'hB2.
  - Then assert dout_ready for 1 cycle -> dout_valid=0.
- Back-to-back, MSB_FIRST=1: dout_ready=1 on the completion edge of the second word -> dout_valid never drops and dout changes from 8'hB2 to 8'h0F.
- Gaps and clear:
  - din_valid toggling 1/0 -> word still correct after 8 valid bits.
  - clear=1 together with din_valid=1 after 5 bits -> bit_cnt=0. The next 8 valid bits form a fresh word, and any pending dout is untouched.
